// File: rtl/exu_commit_unit_pkg.sv
// Shared definitions for the EXU commit stage: trap cause codes, FSM states
// and the decoded-exception record passed from the priority encoder to the top.
package exu_commit_unit_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int PC_SIZE_DEF = 32;

  localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL    = 4'd11;

  typedef enum logic [1:0] {
    CMT_RUN   = 2'd0,
    CMT_FLUSH = 2'd1,
    CMT_HALT  = 2'd2
  } cmt_state_e;

  typedef struct packed {
    logic       trap;
    logic       halt;
    logic [3:0] cause;
  } excp_t;

  function automatic logic is_misaligned(input logic [1:0] tgt_lsb);
    return tgt_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/exu_commit_unit_if.sv
// Commit-side handshake from the ALU path plus the redirect handshake to the IFU.
interface exu_commit_unit_if #(
  parameter int PC_SIZE = 32
);
  logic               cmt_i_valid;
  logic               cmt_i_ready;
  logic [PC_SIZE-1:0] cmt_i_pc;
  logic [31:0]        cmt_i_instr;
  logic               cmt_i_illegal;
  logic               cmt_i_ecall;
  logic               cmt_i_ebreak;
  logic               cmt_i_br_taken;
  logic [PC_SIZE-1:0] cmt_i_br_tgt;
  logic               flush_o_valid;
  logic               flush_o_ready;
  logic [PC_SIZE-1:0] flush_o_pc;

  modport master (
    output cmt_i_valid, cmt_i_pc, cmt_i_instr, cmt_i_illegal, cmt_i_ecall,
           cmt_i_ebreak, cmt_i_br_taken, cmt_i_br_tgt, flush_o_ready,
    input  cmt_i_ready, flush_o_valid, flush_o_pc
  );

  modport slave (
    input  cmt_i_valid, cmt_i_pc, cmt_i_instr, cmt_i_illegal, cmt_i_ecall,
           cmt_i_ebreak, cmt_i_br_taken, cmt_i_br_tgt, flush_o_ready,
    output cmt_i_ready, flush_o_valid, flush_o_pc
  );
endinterface

// File: rtl/exu_cmt_excp_dec.sv
// Priority encoder for commit-time traps: illegal > ebreak > ecall > misaligned target.
module exu_cmt_excp_dec
  import exu_commit_unit_pkg::*;
#(
  parameter bit HALT_ON_EBREAK = 1'b1
) (
  input  logic       illegal,
  input  logic       ecall,
  input  logic       ebreak,
  input  logic       br_taken,
  input  logic [1:0] br_tgt_lsb,
  output excp_t      excp
);

  always_comb begin
    excp = '{trap: 1'b0, halt: 1'b0, cause: CAUSE_MISALIGN};
    if (illegal) begin
      excp.trap  = 1'b1;
      excp.cause = CAUSE_ILLEGAL;
    end else if (ebreak) begin
      excp.trap  = 1'b1;
      excp.halt  = HALT_ON_EBREAK;
      excp.cause = CAUSE_EBREAK;
    end else if (ecall) begin
      excp.trap  = 1'b1;
      excp.cause = CAUSE_ECALL;
    end else if (br_taken && is_misaligned(br_tgt_lsb)) begin
      excp.trap  = 1'b1;
      excp.cause = CAUSE_MISALIGN;
    end
  end

endmodule

// File: rtl/exu_commit_unit.sv
// Commit stage: retires completed instructions or turns them into traps, and
// issues a registered redirect to the IFU for taken branches and trap entry.
module exu_commit_unit
  import exu_commit_unit_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int PC_SIZE        = PC_SIZE_DEF,
  parameter int CNT_W          = 64,
  parameter bit HALT_ON_EBREAK = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  exu_commit_unit_if.slave    cmt_if,
  input  logic [XLEN-1:0]     mtvec_i,
  output logic                commit_trap,
  output logic [XLEN-1:0]     cmt_cause,
  output logic [PC_SIZE-1:0]  cmt_epc,
  output logic [CNT_W-1:0]    retire_cnt
);

  cmt_state_e         state_reg, state_next;
  logic [PC_SIZE-1:0] flush_pc_reg, flush_pc_next;
  logic [XLEN-1:0]    cause_reg, cause_next;
  logic [PC_SIZE-1:0] epc_reg, epc_next;
  logic               trap_reg, trap_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               accept;
  excp_t              excp;
  logic               unused_bits;

  exu_cmt_excp_dec #(
    .HALT_ON_EBREAK (HALT_ON_EBREAK)
  ) u_excp_dec (
    .illegal    (cmt_if.cmt_i_illegal),
    .ecall      (cmt_if.cmt_i_ecall),
    .ebreak     (cmt_if.cmt_i_ebreak),
    .br_taken   (cmt_if.cmt_i_br_taken),
    .br_tgt_lsb (cmt_if.cmt_i_br_tgt[1:0]),
    .excp       (excp)
  );

  // Ready is gated by reset itself so nothing is accepted while rst is held low.
  assign cmt_if.cmt_i_ready   = rst & (state_reg == CMT_RUN);
  assign accept               = cmt_if.cmt_i_valid & cmt_if.cmt_i_ready;
  assign cmt_if.flush_o_valid = (state_reg == CMT_FLUSH);
  assign cmt_if.flush_o_pc    = flush_pc_reg;

  assign commit_trap = trap_reg;
  assign cmt_cause   = cause_reg;
  assign cmt_epc     = epc_reg;
  assign retire_cnt  = cnt_reg;

  // The raw instruction word travels with the commit for debug visibility only.
  assign unused_bits = ^{cmt_if.cmt_i_instr, mtvec_i[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= CMT_RUN;
      flush_pc_reg <= '0;
      cause_reg    <= '0;
      epc_reg      <= '0;
      trap_reg     <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      flush_pc_reg <= flush_pc_next;
      cause_reg    <= cause_next;
      epc_reg      <= epc_next;
      trap_reg     <= trap_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    flush_pc_next = flush_pc_reg;
    cause_next    = cause_reg;
    epc_next      = epc_reg;
    trap_next     = trap_reg;
    cnt_next      = cnt_reg;

    unique case (state_reg)
      CMT_RUN: begin
        if (accept) begin
          if (!excp.trap) begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (cmt_if.cmt_i_br_taken) begin
              flush_pc_next = cmt_if.cmt_i_br_tgt;
              state_next    = CMT_FLUSH;
            end
          end else begin
            cause_next = XLEN'(excp.cause);
            epc_next   = cmt_if.cmt_i_pc;
            if (excp.halt) begin
              trap_next  = 1'b1;
              state_next = CMT_HALT;
            end else begin
              // Trap vector is always entered word-aligned (direct mode).
              flush_pc_next = {mtvec_i[PC_SIZE-1:2], 2'b00};
              state_next    = CMT_FLUSH;
            end
          end
        end
      end
      CMT_FLUSH: begin
        if (cmt_if.flush_o_ready) begin
          state_next = CMT_RUN;
        end
      end
      CMT_HALT: begin
        state_next = CMT_HALT;
      end
      default: begin
        state_next = CMT_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_exu_commit_unit.sv
// Bench for exu_commit_unit: two instances (halting / trapping EBREAK, 64/4-bit
// counters) driven by shared stimulus and compared every cycle to a reference.
module tb_exu_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        t_valid, t_ill, t_ecall, t_ebreak, t_taken, t_fready;
  logic [31:0] t_pc, t_tgt, t_instr, t_mtvec;

  logic        trap0, trap1;
  logic [31:0] cause0, cause1, epc0, epc1;
  logic [63:0] cnt0;
  logic [3:0]  cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exu_commit_unit_if #(.PC_SIZE(32)) if0 ();
  exu_commit_unit_if #(.PC_SIZE(32)) if1 ();

  assign if0.cmt_i_valid    = t_valid;
  assign if0.cmt_i_pc       = t_pc;
  assign if0.cmt_i_instr    = t_instr;
  assign if0.cmt_i_illegal  = t_ill;
  assign if0.cmt_i_ecall    = t_ecall;
  assign if0.cmt_i_ebreak   = t_ebreak;
  assign if0.cmt_i_br_taken = t_taken;
  assign if0.cmt_i_br_tgt   = t_tgt;
  assign if0.flush_o_ready  = t_fready;
  assign if1.cmt_i_valid    = t_valid;
  assign if1.cmt_i_pc       = t_pc;
  assign if1.cmt_i_instr    = t_instr;
  assign if1.cmt_i_illegal  = t_ill;
  assign if1.cmt_i_ecall    = t_ecall;
  assign if1.cmt_i_ebreak   = t_ebreak;
  assign if1.cmt_i_br_taken = t_taken;
  assign if1.cmt_i_br_tgt   = t_tgt;
  assign if1.flush_o_ready  = t_fready;

  exu_commit_unit #(.XLEN(32), .PC_SIZE(32), .CNT_W(64), .HALT_ON_EBREAK(1'b1)) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .cmt_if      (if0.slave),
    .mtvec_i     (t_mtvec),
    .commit_trap (trap0),
    .cmt_cause   (cause0),
    .cmt_epc     (epc0),
    .retire_cnt  (cnt0)
  );

  exu_commit_unit #(.XLEN(32), .PC_SIZE(32), .CNT_W(4), .HALT_ON_EBREAK(1'b0)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .cmt_if      (if1.slave),
    .mtvec_i     (t_mtvec),
    .commit_trap (trap1),
    .cmt_cause   (cause1),
    .cmt_epc     (epc1),
    .retire_cnt  (cnt1)
  );

  // Reference model: index 0 halts on EBREAK with a 64-bit counter,
  // index 1 traps on EBREAK with a counter that wraps at 16.
  bit          m_flush[2], m_halt[2], m_trap[2];
  logic [31:0] m_fpc[2], m_cause[2], m_epc[2];
  logic [63:0] m_cnt[2];

  function automatic int cause_of(input logic ill, ecall, ebreak, taken, input logic [31:0] tgt);
    if (ill) return 2;
    if (ebreak) return 3;
    if (ecall) return 11;
    if (taken && (tgt % 4) != 0) return 0;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_flush[i] <= 1'b0; m_halt[i] <= 1'b0; m_trap[i] <= 1'b0;
        m_fpc[i] <= '0; m_cause[i] <= '0; m_epc[i] <= '0; m_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_halt[i]) begin
          m_halt[i] <= 1'b1;
        end else if (m_flush[i]) begin
          if (t_fready) m_flush[i] <= 1'b0;
        end else if (t_valid) begin
          if (cause_of(t_ill, t_ecall, t_ebreak, t_taken, t_tgt) < 0) begin
            m_cnt[i] <= (i == 0) ? m_cnt[i] + 1 : (m_cnt[i] + 1) % 16;
            if (t_taken) begin
              m_fpc[i]   <= t_tgt;
              m_flush[i] <= 1'b1;
            end
          end else begin
            m_cause[i] <= 32'(cause_of(t_ill, t_ecall, t_ebreak, t_taken, t_tgt));
            m_epc[i]   <= t_pc;
            if (cause_of(t_ill, t_ecall, t_ebreak, t_taken, t_tgt) == 3 && i == 0) begin
              m_trap[i] <= 1'b1;
              m_halt[i] <= 1'b1;
            end else begin
              m_fpc[i]   <= t_mtvec - (t_mtvec % 4);
              m_flush[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("ready0",  64'(if0.cmt_i_ready),   64'(rst && !m_flush[0] && !m_halt[0]));
    check("fvalid0", 64'(if0.flush_o_valid), 64'(m_flush[0]));
    check("fpc0",    64'(if0.flush_o_pc),    64'(m_fpc[0]));
    check("trap0",   64'(trap0),             64'(m_trap[0]));
    check("cause0",  64'(cause0),            64'(m_cause[0]));
    check("epc0",    64'(epc0),              64'(m_epc[0]));
    check("cnt0",    cnt0,                   m_cnt[0]);
    check("ready1",  64'(if1.cmt_i_ready),   64'(rst && !m_flush[1] && !m_halt[1]));
    check("fvalid1", 64'(if1.flush_o_valid), 64'(m_flush[1]));
    check("fpc1",    64'(if1.flush_o_pc),    64'(m_fpc[1]));
    check("trap1",   64'(trap1),             64'(m_trap[1]));
    check("cause1",  64'(cause1),            64'(m_cause[1]));
    check("epc1",    64'(epc1),              64'(m_epc[1]));
    check("cnt1",    64'(cnt1),              m_cnt[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    t_valid = 0; t_ill = 0; t_ecall = 0; t_ebreak = 0; t_taken = 0;
  endtask

  task automatic release_flush();
    t_fready = 1'b1;
    tick();
    t_fready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    t_fready = 0; t_pc = '0; t_tgt = '0; t_instr = 32'h0000_0013; t_mtvec = 32'h8000_0203;
    #2 rst = 1'b0;
    tick(); tick();
    check("lit_ready_in_reset", 64'(if0.cmt_i_ready), 64'd0);
    rst = 1'b1;

    // Five back-to-back plain instructions.
    t_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      t_pc = 32'h8000_0000 + 32'(4 * k);
      tick();
    end
    clear_in();
    check("lit_cnt_after5", cnt0, 64'd5);
    check("lit_ready_after5", 64'(if0.cmt_i_ready), 64'd1);

    // Taken aligned branch with redirect held off.
    t_valid = 1; t_taken = 1; t_pc = 32'h8000_0014; t_tgt = 32'h8000_0100;
    tick();
    clear_in();
    for (int j = 0; j < 3; j++) begin
      check("lit_br_fvalid", 64'(if0.flush_o_valid), 64'd1);
      check("lit_br_fpc", 64'(if0.flush_o_pc), 64'h8000_0100);
      check("lit_br_ready", 64'(if0.cmt_i_ready), 64'd0);
      if (j < 2) tick();
    end
    release_flush();
    check("lit_br_run", 64'(if0.cmt_i_ready), 64'd1);
    check("lit_br_cnt", cnt0, 64'd6);

    // ECALL traps to the aligned vector without retiring.
    t_valid = 1; t_ecall = 1; t_pc = 32'h8000_0010; t_mtvec = 32'h8000_0203;
    tick();
    clear_in();
    check("lit_ecall_cause", 64'(cause0), 64'd11);
    check("lit_ecall_epc", 64'(epc0), 64'h8000_0010);
    check("lit_ecall_fpc", 64'(if0.flush_o_pc), 64'h8000_0200);
    check("lit_ecall_cnt", cnt0, 64'd6);
    release_flush();

    // Illegal dominates ecall and ebreak.
    t_valid = 1; t_ill = 1; t_ecall = 1; t_ebreak = 1; t_pc = 32'h8000_0018;
    tick();
    clear_in();
    check("lit_prio_cause", 64'(cause0), 64'd2);
    check("lit_prio_trap", 64'(trap0), 64'd0);
    release_flush();

    // Misaligned branch target.
    t_valid = 1; t_taken = 1; t_pc = 32'h8000_0020; t_tgt = 32'h8000_0102;
    tick();
    clear_in();
    check("lit_mis_cause", 64'(cause0), 64'd0);
    check("lit_mis_cnt", cnt0, 64'd6);
    check("lit_mis_fpc", 64'(if0.flush_o_pc), 64'h8000_0200);
    release_flush();

    // Randomized traffic (no EBREAK so instance 0 keeps running).
    for (int r = 0; r < 400; r++) begin
      t_valid  = ($urandom_range(0, 3) != 0);
      t_pc     = $urandom() & 32'hFFFF_FFFC;
      t_instr  = $urandom();
      t_ill    = ($urandom_range(0, 15) == 0);
      t_ecall  = ($urandom_range(0, 15) == 0);
      t_ebreak = 1'b0;
      t_taken  = ($urandom_range(0, 3) == 0);
      t_tgt    = $urandom();
      if ($urandom_range(0, 3) != 0) t_tgt = t_tgt & 32'hFFFF_FFFC;
      t_mtvec  = $urandom();
      t_fready = $urandom_range(0, 1);
      tick();
    end
    clear_in();
    t_fready = 1'b1;
    tick(); tick();
    t_fready = 1'b0;

    // EBREAK: instance 0 halts, instance 1 traps to the vector.
    t_valid = 1; t_ebreak = 1; t_pc = 32'h8000_0040; t_mtvec = 32'h8000_0300;
    tick();
    clear_in();
    check("lit_ebk_trap", 64'(trap0), 64'd1);
    check("lit_ebk_cause", 64'(cause0), 64'd3);
    check("lit_ebk_fvalid", 64'(if0.flush_o_valid), 64'd0);
    check("lit_ebk1_fvalid", 64'(if1.flush_o_valid), 64'd1);
    check("lit_ebk1_fpc", 64'(if1.flush_o_pc), 64'h8000_0300);
    check("lit_ebk1_cause", 64'(cause1), 64'd3);
    t_valid = 1; t_fready = 1; t_pc = 32'h8000_0044;
    tick(); tick(); tick();
    check("lit_halt_ready", 64'(if0.cmt_i_ready), 64'd0);
    clear_in();
    t_fready = 0;

    // Asynchronous reset out of HALT.
    rst = 1'b0;
    #1;
    check("lit_rst_trap", 64'(trap0), 64'd0);
    check("lit_rst_cause", 64'(cause0), 64'd0);
    check("lit_rst_epc", 64'(epc0), 64'd0);
    check("lit_rst_cnt", cnt0, 64'd0);
    check("lit_rst_fpc", 64'(if0.flush_o_pc), 64'd0);
    check("lit_rst_ready", 64'(if0.cmt_i_ready), 64'd0);
    tick();
    rst = 1'b1;

    // Counter wrap on the 4-bit instance.
    t_valid = 1;
    for (int k = 0; k < 15; k++) begin
      t_pc = 32'h8000_1000 + 32'(4 * k);
      tick();
    end
    check("lit_wrap_15", 64'(cnt1), 64'd15);
    tick();
    clear_in();
    check("lit_wrap_0", 64'(cnt1), 64'd0);
    check("lit_wrap_cnt0", cnt0, 64'd16);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
